seq_rshifter: RTL and testbench
===============================

// Module: seq_rshifter
// PURPOSE
//  Multi-cycle 16-bit right shifter/rotator for the ALU shift path; mirror of the left barrel shifter.
//  Resolves one shift-amount bit per clock (1,2,4,8 positions), reusing a single shift stage.
//  Fixed latency of CNT_W cycles, with a start/busy/done handshake to the ALU control FSM.
//  Supports logical shift right, arithmetic shift right and rotate right.
// PARAMETERS
//  WIDTH  16  data width in bits
//  CNT_W  4   shift-amount width in bits; equals log2(WIDTH); also the latency in cycles
// PORTS
//  clk    in   1      system clock; all state changes on the rising edge
//  rst    in   1      asynchronous reset, active-high
//  start  in   1      request strobe; sampled only while idle (busy=0)
//  In     in   WIDTH  operand; captured when start is accepted
//  Cnt    in   CNT_W  shift amount, 0..WIDTH-1; captured when start is accepted
//  Op     in   2      00=SRL, 01=SRA, 10=ROR, 11=SRL
//  busy   out  1      high from the cycle after acceptance until the result is written
//  done   out  1      one-cycle pulse: Out holds a new result
//  Out    out  WIDTH  result; holds its value until the next completion
// BEHAVIOUR
//  Reset (async, any state): state=IDLE, Out=0, busy=0, done=0; internal regs cleared.
//   Reset aborts any operation in flight; no done pulse follows.
//  States:
//   IDLE: if start, latch In->acc, Cnt->cnt_r, Op->op_r; step=0; go to SHIFT; busy=1 next cycle.
//   SHIFT: each edge, if cnt_r[step], shift acc right by 2^step; otherwise hold. step increments.
//    On the edge where step==CNT_W-1: write final acc to Out; set done=1 and busy=0; go to IDLE.
//  Latency: start sampled at edge E0; stages run on E1..E4 (CNT_W=4).
//   done is high in the cycle after E4; busy is high in the cycles after E0..E3.
//  Fill bits on each right shift by k:
//   SRL: k zeros enter at the MSB.
//   SRA: k copies of the captured In[WIDTH-1] enter at the MSB.
//   ROR: bits shifted out of the LSB re-enter at the MSB.
//  Cnt=0: Out=In after the full CNT_W cycles; the latency is always fixed.
//  start while busy: ignored; captured operands are unaffected.
//  start in the cycle done=1: accepted, since the FSM is already IDLE; this gives back-to-back ops.
//   done drops the next cycle; Out holds until the new result is written.
//  In, Cnt and Op may change freely after acceptance; only the latched copies are used.
//  done is a single-cycle pulse, never held; Out changes only on completion or reset.
//  No combinational path from inputs to outputs; all outputs are registered.
// TESTING
//  1. rst mid-operation (start, then rst after 2 cycles) -> Out=0, busy=0, done=0; no later done.
//  2. SRL In=0x8000 Cnt=15 -> exactly 4 cycles after start: done=1, Out=0x0001.
//  3. SRA In=0x8000 Cnt=15 -> Out=0xFFFF; SRA In=0x7F00 Cnt=4 -> Out=0x07F0.
//  4. ROR In=0x0001 Cnt=1 -> Out=0x8000; ROR In=0x1234 Cnt=8 -> Out=0x3412.
//  5. Cnt=0 with In=0xBEEF, each Op -> Out=0xBEEF after 4 cycles.
//  6. Op=11 In=0xF000 Cnt=4 -> Out=0x0F00, identical to SRL.
//  7. start pulsed while busy with In=0xFFFF -> ignored; the first result is unchanged.
//  8. New start in the done cycle -> second done exactly 4 cycles later.
//     Out keeps the first result until the second result is written.

Source files
------------

// File: rtl/seq_rshifter_if.sv
// Handshake and operand bundle between the ALU control FSM (master) and the
// multi-cycle right shifter (slave).
interface seq_rshifter_if #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 4
);
    logic             start;
    logic [WIDTH-1:0] In;
    logic [CNT_W-1:0] Cnt;
    logic [1:0]       Op;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] Out;

    modport master (output start, In, Cnt, Op, input busy, done, Out);
    modport slave  (input start, In, Cnt, Op, output busy, done, Out);
endinterface

// File: rtl/seq_rshifter.sv
// Multi-cycle 16-bit right shifter/rotator: resolves one shift-amount bit per
// clock through a single shared shift stage, with fixed CNT_W-cycle latency.
module seq_rshifter #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 4
) (
    input  logic           clk,
    input  logic           rst,
    seq_rshifter_if.slave  bus
);
    localparam int STEP_W = (CNT_W > 1) ? $clog2(CNT_W) : 1;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // One right shift/rotate by sh_amt; SRA fill relies on acc keeping the captured sign in its MSB.
    function automatic logic [WIDTH-1:0] shift_stage(
        input logic [WIDTH-1:0] val,
        input logic [1:0]       op,
        input logic [CNT_W-1:0] sh_amt
    );
        case (op)
            2'b01:   shift_stage = $signed(val) >>> sh_amt;
            2'b10:   shift_stage = WIDTH'({val, val} >> sh_amt);
            default: shift_stage = val >> sh_amt;
        endcase
    endfunction

    state_t            state_r, state_s;
    logic [WIDTH-1:0]  acc_r, acc_s;
    logic [CNT_W-1:0]  cnt_r, cnt_s;
    logic [1:0]        op_r, op_s;
    logic [STEP_W-1:0] step_r, step_s;
    logic [WIDTH-1:0]  out_r, out_s;
    logic              busy_r, busy_s;
    logic              done_r, done_s;
    logic [CNT_W-1:0]  sh_amt_s;
    logic [WIDTH-1:0]  stage_s;

    assign sh_amt_s = CNT_W'(1) << step_r;
    assign stage_s  = shift_stage(acc_r, op_r, sh_amt_s);

    // Next-state and datapath decode; done defaults low so it can only ever pulse.
    always_comb begin
        state_s = state_r;
        acc_s   = acc_r;
        cnt_s   = cnt_r;
        op_s    = op_r;
        step_s  = step_r;
        out_s   = out_r;
        busy_s  = busy_r;
        done_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.start) begin
                    acc_s   = bus.In;
                    cnt_s   = bus.Cnt;
                    op_s    = bus.Op;
                    step_s  = '0;
                    busy_s  = 1'b1;
                    state_s = SHIFT;
                end else begin
                    busy_s  = 1'b0;
                    state_s = IDLE;
                end
            end
            SHIFT: begin
                if (cnt_r[step_r]) begin
                    acc_s = stage_s;
                end else begin
                    acc_s = acc_r;
                end
                step_s = step_r + STEP_W'(1);
                if (step_r == STEP_W'(CNT_W - 1)) begin
                    out_s   = acc_s;
                    done_s  = 1'b1;
                    busy_s  = 1'b0;
                    state_s = IDLE;
                end else begin
                    busy_s  = 1'b1;
                    state_s = SHIFT;
                end
            end
            default: begin
                busy_s  = 1'b0;
                state_s = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            acc_r   <= '0;
            cnt_r   <= '0;
            op_r    <= 2'b00;
            step_r  <= '0;
            out_r   <= '0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            acc_r   <= acc_s;
            cnt_r   <= cnt_s;
            op_r    <= op_s;
            step_r  <= step_s;
            out_r   <= out_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
        end
    end

    assign bus.busy = busy_r;
    assign bus.done = done_r;
    assign bus.Out  = out_r;
endmodule

// File: tb/tb_seq_rshifter.sv
// Scoreboard bench for seq_rshifter: expected results are queued at issue and
// popped on each done pulse.
module tb_seq_rshifter;
    localparam int WIDTH    = 16;
    localparam int CNT_W    = 4;
    localparam int LAT      = CNT_W + 1;
    localparam int MAX_WAIT = 20;

    logic clk = 1'b0;
    logic rst;
    int   vectors     = 0;
    int   miscompares = 0;
    logic [WIDTH-1:0] exp_q[$];
    logic [WIDTH-1:0] last_out = 16'h0000;

    seq_rshifter_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) sif ();

    seq_rshifter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (sif.slave)
    );

    always #5 clk = ~clk;

    // Bit-serial reference model, one position per iteration.
    function automatic logic [15:0] model(input logic [15:0] a, input logic [3:0] c, input logic [1:0] o);
        logic [15:0] r;
        r = a;
        for (int i = 0; i < int'(c); i++) begin
            case (o)
                2'b01:   r = {a[15], r[15:1]};
                2'b10:   r = {r[0], r[15:1]};
                default: r = {1'b0, r[15:1]};
            endcase
        end
        return r;
    endfunction

    // Called at a negedge; returns one negedge later with garbage on the operand inputs.
    task automatic issue(input logic [15:0] a, input logic [3:0] c, input logic [1:0] o);
        sif.In    = a;
        sif.Cnt   = c;
        sif.Op    = o;
        sif.start = 1'b1;
        exp_q.push_back(model(a, c, o));
        @(negedge clk);
        sif.start = 1'b0;
        sif.In    = 16'($urandom);
        sif.Cnt   = 4'($urandom);
        sif.Op    = 2'($urandom);
        vectors++;
        if (sif.busy !== 1'b1) begin
            miscompares++;
            $display("FAIL busy_after_accept: got %b want 1", sif.busy);
        end
    endtask

    task automatic wait_done(input int cyc0, input string tag);
        int cyc;
        logic [15:0] exp;
        cyc = cyc0;
        while (sif.done !== 1'b1 && cyc < MAX_WAIT) begin
            @(negedge clk);
            cyc++;
        end
        vectors++;
        if (cyc != LAT) begin
            miscompares++;
            $display("FAIL %s latency: got %0d want %0d", tag, cyc, LAT);
        end
        if (sif.done === 1'b1 && exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            vectors++;
            if (sif.Out !== exp) begin
                miscompares++;
                $display("FAIL %s Out: got %h want %h", tag, sif.Out, exp);
            end
            vectors++;
            if (sif.busy !== 1'b0) begin
                miscompares++;
                $display("FAIL %s busy_at_done: got %b want 0", tag, sif.busy);
            end
            last_out = exp;
        end
    endtask

    task automatic run_op(input logic [15:0] a, input logic [3:0] c, input logic [1:0] o, input string tag);
        @(negedge clk);
        issue(a, c, o);
        wait_done(1, tag);
        @(negedge clk);
        vectors++;
        if (sif.done !== 1'b0 || sif.Out !== last_out) begin
            miscompares++;
            $display("FAIL %s after_done: done=%b Out=%h want done=0 Out=%h", tag, sif.done, sif.Out, last_out);
        end
    endtask

    task automatic test_reset();
        bit seen;
        @(negedge clk);
        vectors++;
        if (sif.Out !== 16'h0000 || sif.busy !== 1'b0 || sif.done !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_state: Out=%h busy=%b done=%b want 0/0/0", sif.Out, sif.busy, sif.done);
        end
        rst = 1'b0;
        run_op(16'h1234, 4'd4, 2'b00, "pre_reset");
        @(negedge clk);
        issue(16'hFFFF, 4'd3, 2'b00);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        vectors++;
        if (sif.Out !== 16'h0000 || sif.busy !== 1'b0 || sif.done !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_reset: Out=%h busy=%b done=%b want 0/0/0", sif.Out, sif.busy, sif.done);
        end
        exp_q.delete();
        last_out = 16'h0000;
        @(negedge clk);
        rst  = 1'b0;
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (sif.done !== 1'b0 || sif.Out !== 16'h0000) seen = 1'b1;
        end
        vectors++;
        if (seen) begin
            miscompares++;
            $display("FAIL reset_abort: got done/Out activity after reset, want none");
        end
    endtask

    task automatic test_shift_modes();
        run_op(16'h8000, 4'd15, 2'b00, "srl_15");
        run_op(16'h8000, 4'd15, 2'b01, "sra_15");
        run_op(16'h7F00, 4'd4,  2'b01, "sra_pos");
        run_op(16'h0001, 4'd1,  2'b10, "ror_1");
        run_op(16'h1234, 4'd8,  2'b10, "ror_8");
        run_op(16'hF000, 4'd4,  2'b11, "op11");
        for (int o = 0; o < 4; o++) run_op(16'hBEEF, 4'd0, 2'(o), "cnt0");
    endtask

    task automatic test_busy_ignore();
        bit seen;
        @(negedge clk);
        issue(16'h8000, 4'd15, 2'b00);
        sif.start = 1'b1;
        sif.In    = 16'hFFFF;
        sif.Cnt   = 4'd0;
        sif.Op    = 2'b01;
        @(negedge clk);
        sif.start = 1'b0;
        wait_done(2, "busy_ignore");
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (sif.done !== 1'b0 || sif.Out !== last_out) seen = 1'b1;
        end
        vectors++;
        if (seen) begin
            miscompares++;
            $display("FAIL busy_ignore_extra: got extra done or Out change, want none");
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] first;
        @(negedge clk);
        issue(16'h00F0, 4'd4, 2'b00);
        wait_done(1, "b2b_first");
        first = last_out;
        issue(16'h1234, 4'd4, 2'b10);
        repeat (3) begin
            vectors++;
            if (sif.done !== 1'b0 || sif.Out !== first) begin
                miscompares++;
                $display("FAIL b2b_hold: done=%b Out=%h want done=0 Out=%h", sif.done, sif.Out, first);
            end
            @(negedge clk);
        end
        wait_done(4, "b2b_second");
    endtask

    task automatic test_random();
        for (int i = 0; i < 24; i++)
            run_op(16'($urandom), 4'($urandom), 2'($urandom), "random");
    endtask

    initial begin
        rst       = 1'b1;
        sif.start = 1'b0;
        sif.In    = 16'h0000;
        sif.Cnt   = 4'd0;
        sif.Op    = 2'b00;
        test_reset();
        test_shift_modes();
        test_busy_ignore();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end
endmodule
